// File: rtl/dsp_addsub_pipe_pkg.sv
// Shared constants for the two-stage add/subtract pipeline.
// Optional macro: DSP_ADDSUB_SATURATE_EN (clamp on signed overflow).
package dsp_addsub_pipe_pkg;

    localparam int DSP_ADDSUB_WIDTH = 32;

    localparam logic DSP_ADDSUB_OP_ADD = 1'b0;
    localparam logic DSP_ADDSUB_OP_SUB = 1'b1;

    localparam logic [31:0] DSP_ADDSUB_SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] DSP_ADDSUB_SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/dsp_addsub_pipe_if.sv
// Request/response handshake bundle for dsp_addsub_pipe.
// Optional macro: DSP_ADDSUB_SATURATE_EN (no effect on this file).
interface dsp_addsub_pipe_if
    import dsp_addsub_pipe_pkg::*;
#(
    parameter int WIDTH = DSP_ADDSUB_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic             out_overflow;
    logic             out_zero;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_sub,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_result,
        input  out_carry,
        input  out_overflow,
        input  out_zero
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_sub,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_result,
        output out_carry,
        output out_overflow,
        output out_zero
    );

endinterface

// File: rtl/dsp_addsub_half.sv
// Combinational half-width adder with carry in/out.
// Optional macro: DSP_ADDSUB_SATURATE_EN (no effect on this file).
module dsp_addsub_half #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    // Single W-bit carry chain; swap point for a hard DSP block.
    always_comb begin
        {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    end

endmodule

// File: rtl/dsp_addsub_pipe.sv
// Two-stage 32-bit add/subtract, one half-width carry chain per stage.
// Optional macro: DSP_ADDSUB_SATURATE_EN (clamp result on signed overflow).
module dsp_addsub_pipe
    import dsp_addsub_pipe_pkg::*;
#(
    parameter int WIDTH = DSP_ADDSUB_WIDTH
) (
    input logic              clk,
    input logic              rst_n,
    dsp_addsub_pipe_if.slave bus
);

    localparam int H = WIDTH / 2;

`ifdef DSP_ADDSUB_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    logic             s1_valid_q;
    logic             s1_valid_d;
    logic [H-1:0]     s1_sum_lo_q;
    logic [H-1:0]     s1_sum_lo_d;
    logic             s1_carry_lo_q;
    logic             s1_carry_lo_d;
    logic [H-1:0]     s1_a_hi_q;
    logic [H-1:0]     s1_a_hi_d;
    logic [H-1:0]     s1_b_hi_q;
    logic [H-1:0]     s1_b_hi_d;

    logic             s2_valid_q;
    logic             s2_valid_d;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic             carry_q;
    logic             carry_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             zero_q;
    logic             zero_d;

    logic             s2_free;
    logic             s1_free;
    logic             accept;
    logic             advance;
    logic             sub_req;
    logic [WIDTH-1:0] b_eff;
    logic [H-1:0]     lo_sum;
    logic             lo_co;
    logic [H-1:0]     hi_sum;
    logic             hi_co;
    logic             ovf_now;
    logic [WIDTH-1:0] res_now;

    // Ready ripples back from the output; valids never loop combinationally.
    always_comb begin
        s2_free = !s2_valid_q || bus.out_ready;
        s1_free = !s1_valid_q || s2_free;
        accept  = bus.in_valid && s1_free;
        advance = s1_valid_q && s2_free;
        sub_req = (bus.in_sub == DSP_ADDSUB_OP_SUB);
        b_eff   = sub_req ? ~bus.in_b : bus.in_b;
    end

    dsp_addsub_half #(.W(H)) u_lo (
        .a  (bus.in_a[H-1:0]),
        .b  (b_eff[H-1:0]),
        .ci (sub_req),
        .s  (lo_sum),
        .co (lo_co)
    );

    dsp_addsub_half #(.W(H)) u_hi (
        .a  (s1_a_hi_q),
        .b  (s1_b_hi_q),
        .ci (s1_carry_lo_q),
        .s  (hi_sum),
        .co (hi_co)
    );

    // Stage 1: low-half sum plus upper operands (B already inverted for sub).
    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_sum_lo_d   = s1_sum_lo_q;
        s1_carry_lo_d = s1_carry_lo_q;
        s1_a_hi_d     = s1_a_hi_q;
        s1_b_hi_d     = s1_b_hi_q;
        if (accept) begin
            s1_valid_d    = 1'b1;
            s1_sum_lo_d   = lo_sum;
            s1_carry_lo_d = lo_co;
            s1_a_hi_d     = bus.in_a[WIDTH-1:H];
            s1_b_hi_d     = b_eff[WIDTH-1:H];
        end else if (advance) begin
            s1_valid_d    = 1'b0;
        end
    end

    // Stage 2: upper-half sum, flags and optional clamp.
    always_comb begin
        ovf_now = (s1_a_hi_q[H-1] == s1_b_hi_q[H-1])
               && (hi_sum[H-1] != s1_a_hi_q[H-1]);
        res_now = {hi_sum, s1_sum_lo_q};
`ifdef DSP_ADDSUB_SATURATE_EN
        if (ovf_now) begin
            res_now = s1_a_hi_q[H-1] ? SAT_MIN : SAT_MAX;
        end
`endif
        s2_valid_d = s2_valid_q;
        res_d      = res_q;
        carry_d    = carry_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;
        if (advance) begin
            s2_valid_d = 1'b1;
            res_d      = res_now;
            carry_d    = hi_co;
            ovf_d      = ovf_now;
            zero_d     = (res_now == '0);
        end else if (bus.out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    // Pipeline registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_sum_lo_q   <= '0;
            s1_carry_lo_q <= 1'b0;
            s1_a_hi_q     <= '0;
            s1_b_hi_q     <= '0;
            s2_valid_q    <= 1'b0;
            res_q         <= '0;
            carry_q       <= 1'b0;
            ovf_q         <= 1'b0;
            zero_q        <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_sum_lo_q   <= s1_sum_lo_d;
            s1_carry_lo_q <= s1_carry_lo_d;
            s1_a_hi_q     <= s1_a_hi_d;
            s1_b_hi_q     <= s1_b_hi_d;
            s2_valid_q    <= s2_valid_d;
            res_q         <= res_d;
            carry_q       <= carry_d;
            ovf_q         <= ovf_d;
            zero_q        <= zero_d;
        end
    end

    assign bus.in_ready     = s1_free;
    assign bus.out_valid    = s2_valid_q;
    assign bus.out_result   = res_q;
    assign bus.out_carry    = carry_q;
    assign bus.out_overflow = ovf_q;
    assign bus.out_zero     = zero_q;

endmodule

// File: tb/tb_dsp_addsub_pipe.sv
// Scoreboard bench for dsp_addsub_pipe, directed vectors.
// Optional macro: DSP_ADDSUB_SATURATE_EN (selects clamped expectations).
module tb_dsp_addsub_pipe;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        o;
        logic        z;
    } exp_t;

    logic clk;
    logic rst_n;
    int   vectors = 0;
    int   fails   = 0;
    int   pops    = 0;
    int   pops0;
    exp_t sb[$];

    dsp_addsub_pipe_if #(.WIDTH(32)) bus_if ();

    dsp_addsub_pipe #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output side of the scoreboard: compare each result as it is consumed.
    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        if (rst_n && bus_if.out_valid && bus_if.out_ready) begin
            vectors++;
            got = {bus_if.out_result, bus_if.out_carry,
                   bus_if.out_overflow, bus_if.out_zero};
            if (sb.size() == 0) begin
                fails++;
                $error("FAIL unexpected_out got %h required none", got);
            end else begin
                e = sb.pop_front();
                assert (got === e) else begin
                    fails++;
                    $error("FAIL result got r=%h c%b o%b z%b required r=%h c%b o%b z%b",
                           got.r, got.c, got.o, got.z, e.r, e.c, e.o, e.z);
                end
                pops++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] req);
        vectors++;
        assert (got === req) else begin
            fails++;
            $error("FAIL %s got %0h required %0h", tag, got, req);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] er,
                        input logic ec, input logic eo, input logic ez);
        bit   done;
        exp_t e;
        done = 1'b0;
        e = {er, ec, eo, ez};
        bus_if.in_valid = 1'b1;
        bus_if.in_a     = a;
        bus_if.in_b     = b;
        bus_if.in_sub   = sub;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (bus_if.in_ready) begin
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus_if.in_valid = 1'b0;
        if (!done) begin
            vectors++;
            fails++;
            $error("FAIL accept_timeout got in_ready=0 required 1");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) begin
            @(posedge clk);
        end
        #1;
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_a      = '0;
        bus_if.in_b      = '0;
        bus_if.in_sub    = 1'b0;
        bus_if.out_ready = 1'b1;

        #12;
        chk("rst_valid", 64'(bus_if.out_valid), 64'd0);
        chk("rst_outs", {bus_if.out_result, bus_if.out_carry,
                         bus_if.out_overflow, bus_if.out_zero}, 64'd0);
        chk("rst_ready", 64'(bus_if.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("lat_c1", 64'(bus_if.out_valid), 64'd0);
        @(negedge clk);
        chk("lat_c2", 64'(bus_if.out_valid), 64'd1);
        drain();

        @(posedge clk);
        #1;
        send(32'd1, 32'd2, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        send(32'd5, 32'd5, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
        send(32'h0000_FFFF, 32'd1, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
`ifdef DSP_ADDSUB_SATURATE_EN
        send(32'h7FFF_FFFF, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        send(32'h8000_0000, 32'd1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
`else
        send(32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        send(32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
`endif
        drain();

        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
        send(32'd1, 32'd1, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);
        send(32'd2, 32'd2, 1'b0, 32'd4, 1'b0, 1'b0, 1'b0);
        bus_if.in_valid = 1'b1;
        bus_if.in_a     = 32'd3;
        bus_if.in_b     = 32'd3;
        bus_if.in_sub   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_ready", 64'(bus_if.in_ready), 64'd0);
            chk("bp_hold", {bus_if.out_valid, bus_if.out_result}, {1'b1, 32'd2});
            @(posedge clk);
            #1;
        end
        bus_if.out_ready = 1'b1;
        pops0 = pops;
        send(32'd3, 32'd3, 1'b0, 32'd6, 1'b0, 1'b0, 1'b0);
        send(32'd4, 32'd4, 1'b0, 32'd8, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        chk("bp_rate", 64'(pops - pops0), 64'd4);
        @(negedge clk);
        chk("bp_empty", 64'(bus_if.out_valid), 64'd0);
        drain();

        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
        send(32'd10, 32'd20, 1'b0, 32'd30, 1'b0, 1'b0, 1'b0);
        send(32'd30, 32'd40, 1'b0, 32'd70, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus_if.out_valid), 64'd0);
        chk("mid_rst_outs", {bus_if.out_result, bus_if.out_carry,
                             bus_if.out_overflow, bus_if.out_zero}, 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        pops0 = pops;
        send(32'd7, 32'd8, 1'b0, 32'd15, 1'b0, 1'b0, 1'b0);
        drain();
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_pops", 64'(pops - pops0), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
